// File: rtl/product_bcd_display_if.sv
// Handshake and display bundle for product_bcd_display.
// master: Load/Product in; slave: Busy/Done, BCD digits, Segments/Anodes out.
interface product_bcd_display_if;
    logic       Load;
    logic [7:0] Product;
    logic       Busy;
    logic       Done;
    logic [3:0] Hundreds;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic [6:0] Segments;
    logic [3:0] Anodes;

    modport master (
        output Load, Product,
        input  Busy, Done, Hundreds, Tens, Ones, Segments, Anodes
    );

    modport slave (
        input  Load, Product,
        output Busy, Done, Hundreds, Tens, Ones, Segments, Anodes
    );
endinterface

// File: rtl/product_bcd_display.sv
// Captures an 8-bit product, converts it to BCD by double-dabble and scans
// it onto a 4-digit active-low seven-segment display. Ports: Clock, Reset, bus.
module product_bcd_display #(
    parameter int REFRESH_DIV = 4,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    product_bcd_display_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic [11:0]   adj;
    logic [19:0]   cat;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        cat = {adj, shift_q} << 1;
        case (state_q)
            IDLE: begin
                if (bus.Load) begin
                    state_d = CONVERT;
                    shift_d = bus.Product;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CONVERT: begin
                bcd_d   = cat[19:8];
                shift_d = cat[7:0];
                cnt_d   = cnt_q + 3'd1;
                // Eighth shift: publish the digits in one step
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hund_d  = cat[19:16];
                    tens_d  = cat[15:12];
                    ones_d  = cat[11:8];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        sel_d  = sel_q;
        if (scan_q == SW'(REFRESH_DIV - 1)) begin
            scan_d = '0;
            sel_d  = sel_q + 2'd1;
        end
        // Decode from next-state digits so segments and anode stay paired
        digit = ones_d;
        blank = 1'b0;
        case (sel_d)
            2'd0: digit = ones_d;
            2'd1: begin
                digit = tens_d;
                blank = BLANK_LZ && (hund_d == 4'd0) && (tens_d == 4'd0);
            end
            2'd2: begin
                digit = hund_d;
                blank = BLANK_LZ && (hund_d == 4'd0);
            end
            default: blank = 1'b1;
        endcase
        seg_d = blank ? 7'b1111111 : seg7(digit);
        an_d  = ~(4'b0001 << sel_d);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            scan_q  <= '0;
            sel_q   <= '0;
            seg_q   <= 7'b1000000;
            an_q    <= 4'b1110;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Hundreds = hund_q;
    assign bus.Tens     = tens_q;
    assign bus.Ones     = ones_q;
    assign bus.Segments = seg_q;
    assign bus.Anodes   = an_q;
endmodule

// File: tb/tb_product_bcd_display.sv
// Self-checking bench for product_bcd_display: two instances (blanking on
// and off) share clock, reset and stimulus; a decimal reference model checks them.
module tb_product_bcd_display;
    localparam int DIV = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    logic [3:0] eh, et, eo;

    product_bcd_display_if b0();
    product_bcd_display_if b1();

    assign b1.Load    = b0.Load;
    assign b1.Product = b0.Product;

    product_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut0 (
        .Clock(clk), .Reset(rst), .bus(b0)
    );
    product_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut1 (
        .Clock(clk), .Reset(rst), .bus(b1)
    );

    always #5 clk = ~clk;

    // edges since reset release
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] exp_seg(int sel, int h, int t, int o,
                                           bit blz);
        logic [6:0] codes [10];
        int d;
        codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000};
        if (sel == 3) return 7'b1111111;
        if (blz && sel == 2 && h == 0) return 7'b1111111;
        if (blz && sel == 1 && h == 0 && t == 0) return 7'b1111111;
        d = (sel == 0) ? o : (sel == 1) ? t : h;
        return codes[d];
    endfunction

    task automatic check_disp(input int n, input string nm);
        int sel;
        logic [3:0] an;
        logic [6:0] s0, s1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sel = (cyc / DIV) % 4;
            an  = ~(4'b0001 << sel);
            s0  = exp_seg(sel, eh, et, eo, 1'b1);
            s1  = exp_seg(sel, eh, et, eo, 1'b0);
            checks++;
            if (b0.Anodes !== an || b1.Anodes !== an) begin
                errors++;
                $display("FAIL %s anodes: got %b/%b want %b", nm,
                         b0.Anodes, b1.Anodes, an);
            end
            checks++;
            if (b0.Segments !== s0) begin
                errors++;
                $display("FAIL %s seg_blank sel%0d: got %b want %b", nm,
                         sel, b0.Segments, s0);
            end
            checks++;
            if (b1.Segments !== s1) begin
                errors++;
                $display("FAIL %s seg_noblank sel%0d: got %b want %b", nm,
                         sel, b1.Segments, s1);
            end
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (b0.Anodes !== 4'b1110 || b0.Segments !== 7'b1000000 ||
            b1.Segments !== 7'b1000000) begin
            errors++;
            $display("FAIL %s disp: got %b %b want 1110 1000000", nm,
                     b0.Anodes, b0.Segments);
        end
        checks++;
        if (b0.Busy !== 1'b0 || b0.Done !== 1'b0 ||
            {b0.Hundreds, b0.Tens, b0.Ones} !== 12'h000) begin
            errors++;
            $display("FAIL %s state: got busy=%b done=%b %0d/%0d/%0d want 0 0 0/0/0",
                     nm, b0.Busy, b0.Done, b0.Hundreds, b0.Tens, b0.Ones);
        end
    endtask

    task automatic run_conv(input logic [7:0] p, input string nm);
        @(negedge clk);
        b0.Product = p;
        b0.Load    = 1'b1;
        @(negedge clk);
        b0.Load    = 1'b0;
        b0.Product = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (b0.Busy !== 1'b1 || b0.Done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy N+%0d: got busy=%b done=%b want 1 0",
                         nm, k, b0.Busy, b0.Done);
            end
            checks++;
            if ({b0.Hundreds, b0.Tens, b0.Ones} !== {eh, et, eo}) begin
                errors++;
                $display("FAIL %s hold N+%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         nm, k, b0.Hundreds, b0.Tens, b0.Ones, eh, et, eo);
            end
            @(negedge clk);
        end
        eh = 4'(p / 100);
        et = 4'((p / 10) % 10);
        eo = 4'(p % 10);
        checks++;
        if (b0.Busy !== 1'b0 || b0.Done !== 1'b1 || b1.Done !== 1'b1) begin
            errors++;
            $display("FAIL %s done N+8: got busy=%b done=%b want 0 1",
                     nm, b0.Busy, b0.Done);
        end
        checks++;
        if ({b0.Hundreds, b0.Tens, b0.Ones} !== {eh, et, eo} ||
            {b1.Hundreds, b1.Tens, b1.Ones} !== {eh, et, eo}) begin
            errors++;
            $display("FAIL %s digits p=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                     nm, p, b0.Hundreds, b0.Tens, b0.Ones, eh, et, eo);
        end
        @(negedge clk);
        checks++;
        if (b0.Busy !== 1'b0 || b0.Done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle N+9: got busy=%b done=%b want 0 0",
                     nm, b0.Busy, b0.Done);
        end
    endtask

    task automatic test_reset;
        b0.Load    = 1'b0;
        b0.Product = 8'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        eh = 0; et = 0; eo = 0;
        repeat (3) @(negedge clk);
        check_zero("reset_init");
        rst = 1'b0;
        check_disp(7, "scan_after_reset");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("reset_midrun");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known;
        logic [7:0] vals [6];
        vals = '{8'd169, 8'd99, 8'd4, 8'd42, 8'd255, 8'd0};
        for (int i = 0; i < 6; i++) begin
            run_conv(vals[i], $sformatf("known%0d", vals[i]));
            check_disp(4 * DIV + 2, $sformatf("disp%0d", vals[i]));
        end
    endtask

    task automatic test_random;
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
            run_conv(p, "random");
            check_disp(4 * DIV, "random_disp");
        end
    endtask

    task automatic test_ignore_load;
        int dones = 0;
        run_conv(8'd0, "pre_ignore");
        @(negedge clk);
        b0.Product = 8'd169;
        b0.Load    = 1'b1;
        @(negedge clk);
        b0.Load = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (b0.Done === 1'b1) dones++;
            if (k == 8) begin
                checks++;
                if (b0.Done !== 1'b1 ||
                    {b0.Hundreds, b0.Tens, b0.Ones} !== 12'h169) begin
                    errors++;
                    $display("FAIL ignore_load N+8: got done=%b %0d/%0d/%0d want 1 1/6/9",
                             b0.Done, b0.Hundreds, b0.Tens, b0.Ones);
                end
            end
            b0.Load    = (k == 1 || k == 4);
            b0.Product = (k >= 1) ? 8'd40 : 8'd169;
            @(negedge clk);
        end
        b0.Load = 1'b0;
        checks++;
        if (dones != 1 || b0.Busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_load pulses: got %0d busy=%b want 1 0",
                     dones, b0.Busy);
        end
        eh = 1; et = 6; eo = 9;
        run_conv(8'd40, "after_ignore");
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        run_conv(8'd169, "pre_reset");
        @(negedge clk);
        b0.Product = 8'd225;
        b0.Load    = 1'b1;
        @(negedge clk);
        b0.Load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("reset_conv");
        eh = 0; et = 0; eo = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (b0.Done !== 1'b0 || b0.Busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d bad cycles want 0", bad);
        end
        run_conv(8'd225, "after_reset");
        check_disp(4 * DIV, "disp225");
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_ignore_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
